svfile_responder: RTL and testbench

Target-side endpoint for the addr/valid/data/wen/ren/ready request interface driven by the team's initiator blocks. Captures one request at a time and services it against a local bank of DEPTH 64-bit registers after a programmable wait-state count. Acknowledges completion with a one-cycle `ready` pulse and returns read data with the request tag. Sits at the far end of the bus and serves as both a simple register file and a bench-visible target model.

---
 rtl/svfile_responder.sv | 133 +++++++++++++
 tb/tb_svfile_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/svfile_responder.sv
// svfile_responder: register-bank target that acknowledges one request at a time after WAIT_CYCLES wait states.
// Optional error reporting on the err port is enabled by defining SVFILE_RESP_ERR_EN.
module svfile_responder #(
   parameter int PARAM       = 8,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2,
   localparam int TW         = $clog2(PARAM)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   addr,
   input  logic [TW-1:0] valid,
   input  logic [63:0]   data,
   input  logic          wen,
   input  logic          ren,
   output logic          ready,
   output logic [63:0]   rdata,
   output logic [TW-1:0] rtag
`ifdef SVFILE_RESP_ERR_EN
   ,
   output logic          err
`endif
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [7:0] WLOAD = WAIT_CYCLES > 0 ? 8'(WAIT_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            oor_q, oor_d;
   logic [TW-1:0]   tag_q, tag_d;
   logic [63:0]     wdat_q, wdat_d;
   logic            wen_q, wen_d;
   logic            ren_q, ren_d;
   logic            ready_q, ready_d;
   logic [63:0]     rdata_q, rdata_d;
   logic [TW-1:0]   rtag_q, rtag_d;
   logic            accept, ack_d, rd_ok, we;
   logic [63:0]     bank_q [DEPTH];
`ifdef SVFILE_RESP_ERR_EN
   logic            err_q, err_d;
`endif

   // Next state, request capture, and output values computed from the request as it will stand in ACK.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      oor_d   = oor_q;
      tag_d   = tag_q;
      wdat_d  = wdat_q;
      wen_d   = wen_q;
      ren_d   = ren_q;
      accept  = state_q == S_IDLE && valid != '0 && (wen || ren);
      if (accept) begin
         idx_d   = addr[3 +: IW];
         oor_d   = addr[31:3] >= 29'(DEPTH);
         tag_d   = valid;
         wdat_d  = data;
         wen_d   = wen;
         ren_d   = ren;
         state_d = WAIT_CYCLES > 0 ? S_WAIT : S_ACK;
         cnt_d   = WLOAD;
      end else if (state_q == S_WAIT) begin
         state_d = cnt_q == 8'd0 ? S_ACK : S_WAIT;
         cnt_d   = cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
      end else if (state_q == S_ACK) begin
         state_d = S_IDLE;
      end
      ack_d   = state_d == S_ACK;
      rd_ok   = ren_d && !wen_d && !oor_d;
      ready_d = ack_d;
      rdata_d = ack_d && rd_ok ? bank_q[idx_d] : '0;
      rtag_d  = ack_d ? tag_d : '0;
      we      = state_q == S_ACK && wen_q && !ren_q && !oor_q;
`ifdef SVFILE_RESP_ERR_EN
      err_d   = ack_d && (oor_d || (wen_d && ren_d));
`endif
   end

   // State, captured request and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         tag_q   <= '0;
         wdat_q  <= '0;
         wen_q   <= 1'b0;
         ren_q   <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         rtag_q  <= '0;
`ifdef SVFILE_RESP_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         oor_q   <= oor_d;
         tag_q   <= tag_d;
         wdat_q  <= wdat_d;
         wen_q   <= wen_d;
         ren_q   <= ren_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         rtag_q  <= rtag_d;
`ifdef SVFILE_RESP_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   // Register bank: cleared on reset, written on the edge that ends ACK.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      end else if (we) begin
         bank_q[idx_q] <= wdat_q;
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;
   assign rtag  = rtag_q;
`ifdef SVFILE_RESP_ERR_EN
   assign err   = err_q;
`endif
endmodule

// File: tb/tb_svfile_responder.sv
// tb_svfile_responder: directed self-checking bench for svfile_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_svfile_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = '0, addr_z = '0;
   logic [2:0]  valid = '0, valid_z = '0;
   logic [63:0] data = '0, data_z = '0;
   logic        wen = 1'b0, wen_z = 1'b0;
   logic        ren = 1'b0, ren_z = 1'b0;
   logic        ready, ready_z;
   logic [63:0] rdata, rdata_z;
   logic [2:0]  rtag, rtag_z;
`ifdef SVFILE_RESP_ERR_EN
   logic        err, err_z;
`endif
   int          checks = 0;
   int          errors = 0;
   int          lat;
   logic [63:0] rd;
   logic [2:0]  rt;
   logic        er;

   always #5 clk = ~clk;

   svfile_responder #(.PARAM(8), .DEPTH(16), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .addr(addr), .valid(valid), .data(data),
      .wen(wen), .ren(ren), .ready(ready), .rdata(rdata), .rtag(rtag)
`ifdef SVFILE_RESP_ERR_EN
      , .err(err)
`endif
   );

   svfile_responder #(.PARAM(8), .DEPTH(16), .WAIT_CYCLES(0)) dut_z (
      .clk(clk), .reset(reset), .addr(addr_z), .valid(valid_z), .data(data_z),
      .wen(wen_z), .ren(ren_z), .ready(ready_z), .rdata(rdata_z), .rtag(rtag_z)
`ifdef SVFILE_RESP_ERR_EN
      , .err(err_z)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input bit z, input logic [31:0] a, input logic [2:0] t, input logic [63:0] d,
                      input logic w, input logic r, output int l, output logic [63:0] rdo,
                      output logic [2:0] rto, output logic ero);
      l = -1;
      rdo = '0;
      rto = '0;
      ero = 1'b0;
      @(negedge clk);
      if (z) begin
         addr_z = a; valid_z = t; data_z = d; wen_z = w; ren_z = r;
      end else begin
         addr = a; valid = t; data = d; wen = w; ren = r;
      end
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (z ? ready_z : ready) begin
            l = n;
            rdo = z ? rdata_z : rdata;
            rto = z ? rtag_z : rtag;
`ifdef SVFILE_RESP_ERR_EN
            ero = z ? err_z : err;
`endif
            break;
         end
      end
      if (z) begin
         valid_z = '0; wen_z = 1'b0; ren_z = 1'b0;
      end else begin
         valid = '0; wen = 1'b0; ren = 1'b0;
      end
      @(negedge clk);
      chk("ready_single_cycle", 64'(z ? ready_z : ready), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_rdata", rdata, 64'd0);
      chk("reset_rtag", 64'(rtag), 64'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", 64'({ready, ready_z}), 64'd0);
         chk("idle_rdata_rtag", rdata | 64'(rtag), 64'd0);
      end

      // valid without wen/ren is ignored
      @(negedge clk);
      valid = 3'd4;
      repeat (4) begin
         @(negedge clk);
         chk("no_op_ignored", 64'(ready), 64'd0);
      end
      valid = '0;

      req(0, 32'h18, 3'd3, 64'hDEADBEEF_01234567, 1'b1, 1'b0, lat, rd, rt, er);
      chk("wr_latency", 64'(lat), 64'd3);
      chk("wr_rtag", 64'(rt), 64'd3);
      chk("wr_rdata", rd, 64'd0);
      req(0, 32'h18, 3'd5, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("rd_latency", 64'(lat), 64'd3);
      chk("rd_rdata", rd, 64'hDEADBEEF_01234567);
      chk("rd_rtag", 64'(rt), 64'd5);
      req(0, 32'h1C, 3'd1, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("rd_low_bits_ignored", rd, 64'hDEADBEEF_01234567);

      do_reset();
      req(0, 32'h80, 3'd1, 64'h1, 1'b1, 1'b0, lat, rd, rt, er);
      chk("oor_wr_latency", 64'(lat), 64'd3);
`ifdef SVFILE_RESP_ERR_EN
      chk("oor_wr_err", 64'(er), 64'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         req(0, 32'(i * 8), 3'd6, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
         chk("oor_readback_zero", rd, 64'd0);
`ifdef SVFILE_RESP_ERR_EN
         chk("inrange_err", 64'(er), 64'd0);
`endif
      end
      req(0, 32'h00, 3'd1, 64'h5555_AAAA_1234_5678, 1'b1, 1'b0, lat, rd, rt, er);
      req(0, 32'h80, 3'd1, 64'h1, 1'b1, 1'b0, lat, rd, rt, er);
      req(0, 32'h00, 3'd1, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("oor_no_alias", rd, 64'h5555_AAAA_1234_5678);
      req(0, 32'h80, 3'd7, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("oor_rd_zero", rd, 64'd0);
      chk("oor_rd_rtag", 64'(rt), 64'd7);

      req(0, 32'h00, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, lat, rd, rt, er);
      chk("ill_latency", 64'(lat), 64'd3);
      chk("ill_rtag", 64'(rt), 64'd2);
      chk("ill_rdata", rd, 64'd0);
`ifdef SVFILE_RESP_ERR_EN
      chk("ill_err", 64'(er), 64'd1);
`endif
      req(0, 32'h00, 3'd1, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("ill_bank_unchanged", rd, 64'h5555_AAAA_1234_5678);

      @(negedge clk);
      addr = 32'h08; valid = 3'd1; data = 64'hABCD; wen = 1'b1;
      @(negedge clk);
      reset = 1'b0; valid = '0; wen = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("midreset_no_ready", 64'(ready), 64'd0);
      end
      req(0, 32'h08, 3'd1, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("midreset_no_write", rd, 64'd0);
      req(0, 32'h00, 3'd1, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("midreset_bank_cleared", rd, 64'd0);

      req(1, 32'h00, 3'd1, 64'h0, 1'b0, 1'b1, lat, rd, rt, er);
      chk("z_rd_latency", 64'(lat), 64'd1);
      chk("z_rd_rdata", rd, 64'd0);
      req(1, 32'h28, 3'd4, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, lat, rd, rt, er);
      chk("z_wr_latency", 64'(lat), 64'd1);
      @(negedge clk);
      addr_z = 32'h28; valid_z = 3'd6; ren_z = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("z_b2b_ready", 64'(ready_z), 64'(k % 2));
         if (k % 2 == 1) chk("z_b2b_rdata", rdata_z, 64'h0123_4567_89AB_CDEF);
      end
      valid_z = '0; ren_z = 1'b0;
      @(negedge clk);
      chk("z_b2b_idle", 64'(ready_z), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
